// File: rtl/pipe_stage_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg_pkg -- shared widths and state encoding for pipe_stage_reg
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_stage_reg_pkg;

  localparam int unsigned WORD = 32;

  // Encoding equals the number of held entries, so occupancy is the state itself
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg -- valid/ready pipeline register with optional skid entry and flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = WORD,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  ps_state_e        r_state;
  ps_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid_data;
  logic             w_accept;
  logic             w_consume;
  logic             w_load_in;
  logic             w_pop_skid;
  logic             w_load_skid;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;
  assign out_valid = (r_state != PS_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_pop_skid  = 1'b0;
    w_load_skid = 1'b0;
    if (flush) begin
      w_state_nxt = PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = PS_FULL;
            w_load_in   = 1'b1;
          end
        end
        PS_FULL: begin
          if (w_accept && w_consume) begin
            w_load_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = PS_SKID;
            w_load_skid = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (w_consume) begin
            w_state_nxt = PS_FULL;
            w_pop_skid  = 1'b1;
          end
        end
        default: w_state_nxt = PS_EMPTY;
      endcase
    end
  end

  // Main entry only changes on load, skid pop or flush: stable while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PS_EMPTY;
      r_main  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_main <= RESET_VAL;
      end else if (w_load_in) begin
        r_main <= in_data;
      end else if (w_pop_skid) begin
        r_main <= w_skid_data;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] r_skid;
      logic             r_in_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_skid     <= RESET_VAL;
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != PS_SKID);
          if (flush) begin
            r_skid <= RESET_VAL;
          end else if (w_load_skid) begin
            r_skid <= in_data;
          end
        end
      end

      assign w_skid_data = r_skid;
      assign in_ready    = r_in_ready;
    end else begin : g_single
      // Without a skid slot the FULL state can only reload when the consumer drains it
      assign w_skid_data = r_main;
      assign in_ready    = (r_state == PS_EMPTY) | out_ready;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg -- checks SKID=1 and SKID=0 instances against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/100ps
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int          W     = WORD;
  localparam int          CYCLE = 20;
  localparam logic [W-1:0] RV0  = '0;
  localparam logic [W-1:0] RV1  = 32'h0000_00A5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          v[2];
  logic          ordy[2];
  logic          ir[2];
  logic          ov[2];
  logic [W-1:0]  d[2];
  logic [W-1:0]  od[2];
  logic [1:0]    occ[2];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #(CYCLE/2) clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV0), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v[0]), .in_ready(ir[0]), .in_data(d[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV1), .SKID(1'b0)) u_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v[1]), .in_ready(ir[1]), .in_data(d[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occupancy(occ[1])
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rv(input int i);
    return (i == 0) ? RV0 : RV1;
  endfunction

  // Model: per instance a FIFO of up to two bundles plus the last value shown
  logic [W-1:0] m_ent[2][2];
  logic [W-1:0] m_last[2] = '{RV0, RV1};
  int           m_cnt[2]  = '{0, 0};
  int           rst_cnt   = 0;

  function automatic logic m_ready(input int i);
    if (i == 0) return (m_cnt[0] < 2);
    return (m_cnt[1] == 0) || ordy[1];
  endfunction

  function automatic logic [W-1:0] m_data(input int i);
    return (m_cnt[i] > 0) ? m_ent[i][0] : m_last[i];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic acc;
    logic con;
    if (reset) rst_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (reset || flush) begin
        m_cnt[i]  = 0;
        m_last[i] = rv(i);
      end else begin
        acc = v[i] && m_ready(i);
        con = (m_cnt[i] > 0) && ordy[i];
        if (con) begin
          m_last[i]    = m_ent[i][0];
          m_ent[i][0]  = m_ent[i][1];
          m_cnt[i]     = m_cnt[i] - 1;
        end
        if (acc && m_cnt[i] < 2) begin
          m_ent[i][m_cnt[i]] = d[i];
          m_cnt[i]           = m_cnt[i] + 1;
        end
      end
    end
  end

  bit           p_hold[2] = '{1'b0, 1'b0};
  logic [W-1:0] p_od[2];
  int           p_rst = 0;

  always @(negedge clk) begin
    #2;
    if (cmp_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("out_valid[%0d]", i), ov[i], m_cnt[i] > 0);
        chk($sformatf("out_data[%0d]", i), od[i], m_data(i));
        chk($sformatf("occupancy[%0d]", i), occ[i], m_cnt[i]);
        chk($sformatf("in_ready[%0d]", i), ir[i], m_ready(i));
        if (p_hold[i] && ov[i] && p_rst == rst_cnt)
          chk($sformatf("stall_stable[%0d]", i), od[i], p_od[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      p_hold[i] = ov[i] && !ordy[i] && !flush && !reset;
      p_od[i]   = od[i];
    end
    p_rst = rst_cnt;
  end

  task automatic drive(input logic vv, input logic [W-1:0] dd, input logic rr, input logic ff);
    for (int i = 0; i < 2; i++) begin
      v[i]    = vv;
      d[i]    = dd;
      ordy[i] = rr;
    end
    flush = ff;
  endtask

  // Reset asserted mid-cycle for CYCLE/5, checked while asserted before the next edge
  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #3 reset = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s out_valid[%0d]", nm, i), ov[i], 1'b0);
      chk($sformatf("%s out_data[%0d]", nm, i), od[i], rv(i));
      chk($sformatf("%s occupancy[%0d]", nm, i), occ[i], 2'd0);
      chk($sformatf("%s in_ready[%0d]", nm, i), ir[i], 1'b1);
    end
    #2 reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;

    pulse_reset("reset");

    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) drive(1'b1, W'(k), 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b1, 1'b0);
      if (k > 1) begin
        #1;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("stream data[%0d]", i), od[i], W'(k - 1));
          chk($sformatf("stream valid[%0d]", i), ov[i], 1'b1);
        end
      end
    end

    @(negedge clk); drive(1'b1, W'(10), 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, W'(11), 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("stall occ skid", occ[0], 2'd2);
    chk("stall in_ready skid", ir[0], 1'b0);
    chk("stall data skid", od[0], W'(10));
    chk("stall occ single", occ[1], 2'd1);
    chk("stall in_ready single", ir[1], 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("release first skid", od[0], W'(10));
    chk("release first single", od[1], W'(10));
    @(negedge clk); #1;
    chk("release second skid", od[0], W'(11));
    chk("release second valid", ov[0], 1'b1);
    chk("release single drained", ov[1], 1'b0);
    @(negedge clk); #1;
    chk("release skid drained", ov[0], 1'b0);

    @(negedge clk); drive(1'b1, W'(20), 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, W'(21), 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, W'(22), 1'b0, 1'b1);
    #1;
    chk("preflush occ", occ[0], 2'd2);
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("flush occ[%0d]", i), occ[i], 2'd0);
      chk($sformatf("flush valid[%0d]", i), ov[i], 1'b0);
      chk($sformatf("flush data[%0d]", i), od[i], rv(i));
      chk($sformatf("flush in_ready[%0d]", i), ir[i], 1'b1);
    end
    @(negedge clk); drive(1'b1, W'(23), 1'b1, 1'b1);
    #1;
    chk("flush empty in_ready", ir[0], 1'b1);
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) begin
      #1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("flushed not delivered[%0d]", i), ov[i], 1'b0);
      @(negedge clk);
    end

    drive(1'b1, W'(30), 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("hold 30", od[0], W'(30));
    pulse_reset("midstall");

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        v[i]    = ($urandom_range(0, 3) != 0);
        d[i]    = $urandom;
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
